triangle_fetch_ctrl: RTL and testbench
======================================

TRIANGLE_FETCH_CTRL -- requirements
Module: triangle_fetch_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-003 SHALL have port start, input, 1, one-cycle pulse that starts a frame fetch.
REQ-004 SHALL have port base_addr, input, 32, byte address of the first triangle.
REQ-005 SHALL have port tri_count, input, 16, triangles in the frame.
REQ-006 SHALL have port mem_req, output, 1, memory read request.
REQ-007 SHALL have port mem_addr, output, 32, read address; word-aligned.
REQ-008 SHALL have port mem_grant, input, 1, request accepted this cycle.
REQ-009 SHALL have port mem_rvalid, input, 1, read data valid this cycle.
REQ-010 SHALL have port mem_rdata, input, 32, read data.
REQ-011 SHALL have port ahb_buffer, output, 32, word presented to the texel assembler.
REQ-012 SHALL have port ahb_data_available, output, 1, ahb_buffer is valid.
REQ-013 SHALL have port ahb_user_read_buffer, input, 1, assembler consumes ahb_buffer.
REQ-014 SHALL have port texel_ready, input, 1, assembler holds an unread triangle.
REQ-015 SHALL have port busy, output, 1, frame fetch in progress.
REQ-016 SHALL have port done, output, 1, one-cycle pulse at frame completion.
REQ-017 SHALL have port tri_sent, output, 16, triangles fully delivered this frame.

Function
REQ-018 SHALL implement states IDLE, DRAIN, MARK_S, REQ, WAIT, PUSH, MARK_E, FIN.
REQ-019 IDLE: on start, latch base_addr into addr and tri_count into remaining, clear tri_sent, and go to DRAIN. If tri_count==0, go to FIN instead.
REQ-020 SHALL ignore start in every state except IDLE.
REQ-021 DRAIN: wait while texel_ready==1; when texel_ready==0, go to MARK_S.
REQ-022 MARK_S: present 32'h00000000 (FRAME_START).
REQ-023 REQ: assert mem_req with mem_addr=addr until mem_grant; on grant, go to WAIT.
REQ-024 WAIT: on mem_rvalid, capture mem_rdata and go to PUSH.
REQ-025 Only one memory read SHALL be outstanding at any time.
REQ-026 PUSH: present the captured word.
REQ-027 A presented word SHALL be held stable with ahb_data_available=1 until a rising edge where ahb_user_read_buffer==1; the transfer completes on that edge.
REQ-028 Transfer completion in PUSH SHALL set addr=addr+4 and return to REQ, or go to MARK_E after the 6th data word of the triangle.
REQ-029 MARK_E: present 32'h00000001 (FRAME_END).
REQ-030 On MARK_E transfer completion: tri_sent+1, remaining-1; go to DRAIN if remaining>0, else FIN.
REQ-031 Each triangle SHALL deliver exactly 8 words in order: FRAME_START, data0..data5, FRAME_END. Memory holds 6 words (24 bytes) per triangle, contiguous.
REQ-032 FIN: assert done for exactly one cycle, then go to IDLE.
REQ-033 busy SHALL be 1 in every state except IDLE.
REQ-034 ahb_data_available SHALL be 1 only in MARK_S, PUSH and MARK_E.
REQ-035 addr SHALL wrap modulo 2^32.
REQ-036 mem_rvalid outside WAIT SHALL be ignored.

Reset
REQ-037 On rst: state=IDLE; mem_req=0; mem_addr=0; ahb_buffer=0; ahb_data_available=0; busy=0; done=0; tri_sent=0. Takes effect immediately, including mid-frame; any outstanding read is dropped.

Configuration
REQ-038 Macro TRI_FETCH_TIMEOUT_EN defined: a cycle counter runs in WAIT.
- 256 consecutive cycles without mem_rvalid: set sticky output timeout_err (1 bit, reset 0), go to FIN.
- timeout_err clears on the next accepted start.
REQ-039 Macro TRI_FETCH_TIMEOUT_EN undefined: no counter and no timeout_err port; WAIT waits indefinitely.

Verification
REQ-040 Single triangle: start, base_addr=0x100, tri_count=1, memory returns 0x33221100..0xFEDBCA98, read_buffer tied 1 -> ahb_buffer sequence 0, six data words, 1; addresses 0x100..0x114; done pulses once; tri_sent=1.
REQ-041 Back-pressure: ahb_user_read_buffer low for 5 cycles during PUSH -> ahb_buffer and ahb_data_available stay stable; no extra mem_req.
REQ-042 Drain gating: tri_count=2, texel_ready held 1 for 10 cycles after the first FRAME_END -> no FRAME_START until texel_ready falls; tri_sent=2 at done.
REQ-043 Zero count: start with tri_count=0 -> busy for 1 cycle, done pulses, no mem_req.
REQ-044 Reset mid-frame: assert rst during WAIT of triangle 1 -> all outputs reach reset values asynchronously; a later start fetches from the new base_addr.
REQ-045 With TRI_FETCH_TIMEOUT_EN: withhold mem_rvalid for 256 cycles -> timeout_err=1, done pulses, state IDLE.

Source files
------------

// File: rtl/triangle_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// triangle_fetch_ctrl
//
// Purpose:
//   Fetches a frame of triangles from memory and streams them, one word at a
//   time, to the texel assembler. Each triangle is framed as
//   FRAME_START (32'h0), six data words read from memory, FRAME_END (32'h1).
//   Memory holds six contiguous 32-bit words (24 bytes) per triangle.
//   Before each triangle the controller waits for the assembler to drain
//   (texel_ready low). Exactly one memory read is outstanding at a time.
//
// Optional feature (macro TRI_FETCH_TIMEOUT_EN):
//   When defined, a read that sees no mem_rvalid for 256 consecutive cycles
//   aborts the frame, sets the sticky timeout_err output and pulses done.
//   timeout_err clears on the next accepted start.
//
// Ports:
//   clk                   in   sole clock, rising edge
//   rst                   in   asynchronous, active-high reset
//   start                 in   one-cycle pulse, accepted only when idle
//   base_addr[31:0]       in   byte address of the first triangle
//   tri_count[15:0]       in   triangles in the frame
//   mem_req               out  memory read request
//   mem_addr[31:0]        out  word-aligned read address
//   mem_grant             in   request accepted this cycle
//   mem_rvalid            in   read data valid this cycle
//   mem_rdata[31:0]       in   read data
//   ahb_buffer[31:0]      out  word presented to the assembler
//   ahb_data_available    out  ahb_buffer is valid
//   ahb_user_read_buffer  in   assembler consumes ahb_buffer
//   texel_ready           in   assembler still holds an unread triangle
//   busy                  out  frame fetch in progress
//   done                  out  one-cycle pulse at frame completion
//   tri_sent[15:0]        out  triangles fully delivered this frame
//   timeout_err           out  sticky read timeout (TRI_FETCH_TIMEOUT_EN only)
//
// All outputs are flops loaded from next-state values, so they change only
// on a clock edge (or on reset) and are glitch-free.
// ----------------------------------------------------------------------------
module triangle_fetch_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] base_addr,
   input  logic [15:0] tri_count,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_grant,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic [31:0] ahb_buffer,
   output logic        ahb_data_available,
   input  logic        ahb_user_read_buffer,
   input  logic        texel_ready,
   output logic        busy,
   output logic        done,
   output logic [15:0] tri_sent
`ifdef TRI_FETCH_TIMEOUT_EN
   ,
   output logic        timeout_err
`endif
);

   localparam int unsigned ADDR_W        = 32;
   localparam int unsigned DATA_W        = 32;
   localparam int unsigned CNT_W         = 16;
   localparam int unsigned WORDS_PER_TRI = 6;
   localparam int unsigned WCNT_W        = 3;
   localparam int unsigned WORD_BYTES    = 4;
`ifdef TRI_FETCH_TIMEOUT_EN
   localparam int unsigned TO_W          = 8;
`endif

   localparam logic [DATA_W-1:0] FRAME_START = DATA_W'(32'h0000_0000);
   localparam logic [DATA_W-1:0] FRAME_END   = DATA_W'(32'h0000_0001);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_DRAIN  = 3'd1,
      S_MARK_S = 3'd2,
      S_REQ    = 3'd3,
      S_WAIT   = 3'd4,
      S_PUSH   = 3'd5,
      S_MARK_E = 3'd6,
      S_FIN    = 3'd7
   } state_t;

   // FSM and datapath registers
   state_t              state_q,     state_d;
   logic [ADDR_W-1:0]   addr_q,      addr_d;
   logic [CNT_W-1:0]    remaining_q, remaining_d;
   logic [CNT_W-1:0]    tri_sent_q,  tri_sent_d;
   logic [WCNT_W-1:0]   word_cnt_q,  word_cnt_d;
   logic [DATA_W-1:0]   data_q,      data_d;
`ifdef TRI_FETCH_TIMEOUT_EN
   logic [TO_W-1:0]     wait_cnt_q,  wait_cnt_d;
   logic                timeout_q,   timeout_d;
`endif

   // Output registers
   logic                mem_req_q,   mem_req_d;
   logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
   logic [DATA_W-1:0]   ahb_buf_q,   ahb_buf_d;
   logic                ahb_avail_q, ahb_avail_d;
   logic                busy_q,      busy_d;
   logic                done_q,      done_d;

   // A presented word transfers on an edge where the assembler reads it
   logic                xfer;
   assign xfer = ahb_user_read_buffer;

   // State, datapath and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         remaining_q <= '0;
         tri_sent_q  <= '0;
         word_cnt_q  <= '0;
         data_q      <= '0;
`ifdef TRI_FETCH_TIMEOUT_EN
         wait_cnt_q  <= '0;
         timeout_q   <= 1'b0;
`endif
         mem_req_q   <= 1'b0;
         mem_addr_q  <= '0;
         ahb_buf_q   <= '0;
         ahb_avail_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         remaining_q <= remaining_d;
         tri_sent_q  <= tri_sent_d;
         word_cnt_q  <= word_cnt_d;
         data_q      <= data_d;
`ifdef TRI_FETCH_TIMEOUT_EN
         wait_cnt_q  <= wait_cnt_d;
         timeout_q   <= timeout_d;
`endif
         mem_req_q   <= mem_req_d;
         mem_addr_q  <= mem_addr_d;
         ahb_buf_q   <= ahb_buf_d;
         ahb_avail_q <= ahb_avail_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      remaining_d = remaining_q;
      tri_sent_d  = tri_sent_q;
      word_cnt_d  = word_cnt_q;
      data_d      = data_q;
`ifdef TRI_FETCH_TIMEOUT_EN
      wait_cnt_d  = wait_cnt_q;
      timeout_d   = timeout_q;
`endif

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               addr_d      = base_addr;
               remaining_d = tri_count;
               tri_sent_d  = '0;
`ifdef TRI_FETCH_TIMEOUT_EN
               timeout_d   = 1'b0;
`endif
               state_d     = (tri_count == '0) ? S_FIN : S_DRAIN;
            end
         end

         // Hold off the next FRAME_START until the assembler is empty
         S_DRAIN: begin
            if (!texel_ready) begin
               state_d = S_MARK_S;
            end
         end

         S_MARK_S: begin
            if (xfer) begin
               word_cnt_d = '0;
               state_d    = S_REQ;
            end
         end

         S_REQ: begin
            if (mem_grant) begin
`ifdef TRI_FETCH_TIMEOUT_EN
               wait_cnt_d = '0;
`endif
               state_d    = S_WAIT;
            end
         end

         // Single outstanding read: no new request until this data returns
         S_WAIT: begin
            if (mem_rvalid) begin
               data_d  = mem_rdata;
               state_d = S_PUSH;
            end
`ifdef TRI_FETCH_TIMEOUT_EN
            else if (wait_cnt_q == '1) begin
               // 256th consecutive cycle without data: abandon the frame
               timeout_d = 1'b1;
               state_d   = S_FIN;
            end else begin
               wait_cnt_d = wait_cnt_q + TO_W'(1);
            end
`endif
         end

         // Address always advances so the next triangle follows contiguously
         S_PUSH: begin
            if (xfer) begin
               addr_d = addr_q + ADDR_W'(WORD_BYTES);
               if (word_cnt_q == WCNT_W'(WORDS_PER_TRI - 1)) begin
                  state_d = S_MARK_E;
               end else begin
                  word_cnt_d = word_cnt_q + WCNT_W'(1);
                  state_d    = S_REQ;
               end
            end
         end

         S_MARK_E: begin
            if (xfer) begin
               tri_sent_d  = tri_sent_q + CNT_W'(1);
               remaining_d = remaining_q - CNT_W'(1);
               state_d     = (remaining_q > CNT_W'(1)) ? S_DRAIN : S_FIN;
            end
         end

         S_FIN: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output decode from next-state values, loaded into the output flops
   always_comb begin
      mem_req_d   = (state_d == S_REQ);
      mem_addr_d  = {addr_d[ADDR_W-1:2], 2'b00};
      ahb_avail_d = (state_d == S_MARK_S) || (state_d == S_PUSH) ||
                    (state_d == S_MARK_E);
      busy_d      = (state_d != S_IDLE);
      done_d      = (state_d == S_FIN);

      ahb_buf_d = ahb_buf_q;
      case (state_d)
         S_MARK_S: ahb_buf_d = FRAME_START;
         S_PUSH:   ahb_buf_d = data_d;
         S_MARK_E: ahb_buf_d = FRAME_END;
         default:  ahb_buf_d = ahb_buf_q;
      endcase
   end

   assign mem_req            = mem_req_q;
   assign mem_addr           = mem_addr_q;
   assign ahb_buffer         = ahb_buf_q;
   assign ahb_data_available = ahb_avail_q;
   assign busy               = busy_q;
   assign done               = done_q;
   assign tri_sent           = tri_sent_q;
`ifdef TRI_FETCH_TIMEOUT_EN
   assign timeout_err        = timeout_q;
`endif

endmodule

// File: tb/tb_triangle_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// tb_triangle_fetch_ctrl
//
// Self-checking bench for triangle_fetch_ctrl. A memory responder with random
// grant/latency and a stream model (expected word and address queues built
// from the framing rules) check every transfer. Scenario table plus hand
// sequences for zero count, mid-frame reset and (TRI_FETCH_TIMEOUT_EN) the
// read timeout.
// ----------------------------------------------------------------------------
module tb_triangle_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start;
   logic [31:0] base_addr;
   logic [15:0] tri_count;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_grant;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic [31:0] ahb_buffer;
   logic        ahb_data_available;
   logic        ahb_user_read_buffer;
   logic        texel_ready;
   logic        busy;
   logic        done;
   logic [15:0] tri_sent;
`ifdef TRI_FETCH_TIMEOUT_EN
   logic        timeout_err;
`endif

   always #5 clk = ~clk;

   triangle_fetch_ctrl dut (
      .clk                  (clk),
      .rst                  (rst),
      .start                (start),
      .base_addr            (base_addr),
      .tri_count            (tri_count),
      .mem_req              (mem_req),
      .mem_addr             (mem_addr),
      .mem_grant            (mem_grant),
      .mem_rvalid           (mem_rvalid),
      .mem_rdata            (mem_rdata),
      .ahb_buffer           (ahb_buffer),
      .ahb_data_available   (ahb_data_available),
      .ahb_user_read_buffer (ahb_user_read_buffer),
      .texel_ready          (texel_ready),
      .busy                 (busy),
      .done                 (done),
      .tri_sent             (tri_sent)
`ifdef TRI_FETCH_TIMEOUT_EN
      ,
      .timeout_err          (timeout_err)
`endif
   );

   typedef struct {
      logic [31:0] base;
      int          cnt;
      int          rd_pct;
      int          tex_mode;   // 0: always 0, 1: random, 2: high 10 cycles after FRAME_END
      bit          bp;         // hold read_buffer low 5 cycles on first data word
      int          exp_reads;
      int          exp_words;
      int          exp_sent;
   } vec_t;

   int n_chk  = 0;
   int n_pass = 0;

   logic [31:0] exp_words[$];
   logic [31:0] exp_addrs[$];
   bit          pending;
   int          lat;
   logic [31:0] pend_addr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   // Memory contents: fixed words for the reference triangle, hash elsewhere
   // (the hash never yields 0 or 1, so data never looks like a frame marker)
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0000_0100: return 32'h3322_1100;
         32'h0000_0104: return 32'h7766_5544;
         32'h0000_0108: return 32'hBBAA_9988;
         32'h0000_010C: return 32'hFFEE_DDCC;
         32'h0000_0110: return 32'h7654_3210;
         32'h0000_0114: return 32'hFEDB_CA98;
         default:       return {a[15:0], ~a[15:0]} ^ 32'h5A5A_3C3C;
      endcase
   endfunction

   task automatic idle_inputs();
      start = 1'b0; mem_grant = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      ahb_user_read_buffer = 1'b0; texel_ready = 1'b0;
   endtask

   // Runs one frame from IDLE to done and checks every transfer against the model
   task automatic run_frame(input logic [31:0] base, input int cnt, input int rd_pct,
                            input int tex_mode, input bit bp,
                            output int reads, output int words, output int sent,
                            output int dones);
      logic        o_req, o_avail, i_grant, i_rv, i_rd, i_tex;
      logic [31:0] o_addr, o_buf, a, e;
      bit          genuine, bp_used, fin;
      int          hold, bp_cnt;
      reads = 0; words = 0; sent = -1; dones = 0;
      hold = 0; bp_cnt = 0; bp_used = 0; fin = 0; pending = 0; lat = 0; pend_addr = '0;
      exp_words.delete();
      exp_addrs.delete();
      for (int t = 0; t < cnt; t++) begin
         exp_words.push_back(32'h0);
         for (int k = 0; k < 6; k++) begin
            a = (base + 32'(24 * t + 4 * k)) & 32'hFFFF_FFFC;
            exp_addrs.push_back(a);
            exp_words.push_back(mem_word(a));
         end
         exp_words.push_back(32'h1);
      end
      for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
         o_req = mem_req; o_addr = mem_addr; o_avail = ahb_data_available; o_buf = ahb_buffer;
         if (cyc == 0) begin
            start = 1'b1; base_addr = base; tri_count = 16'(cnt);
         end else begin
            start = ($urandom_range(7) == 0); base_addr = $urandom; tri_count = 16'($urandom);
         end
         i_grant = o_req && ($urandom_range(2) != 0);
         genuine = 1'b0;
         if (pending) begin
            if (lat == 0) begin i_rv = 1'b1; genuine = 1'b1; end
            else begin i_rv = 1'b0; lat--; end
         end else begin
            i_rv = ($urandom_range(3) == 0);
         end
         mem_rdata = genuine ? mem_word(pend_addr) : $urandom;
         if (bp && !bp_used && o_avail && exp_words.size() > 0 && exp_words[0] > 32'h1) begin
            bp_cnt = 5; bp_used = 1'b1;
         end
         if (bp_cnt > 0) begin i_rd = 1'b0; bp_cnt--; end
         else i_rd = (int'($urandom_range(99)) < rd_pct);
         case (tex_mode)
            0:       i_tex = 1'b0;
            1:       i_tex = 1'($urandom_range(1));
            default: i_tex = (hold > 0);
         endcase
         if (hold > 0) hold--;
         mem_grant = i_grant; mem_rvalid = i_rv; ahb_user_read_buffer = i_rd; texel_ready = i_tex;

         @(posedge clk); #1;

         if (o_req && i_grant) begin
            reads++;
            chk("single outstanding read", 32'(pending), 32'd0);
            if (exp_addrs.size() == 0) chk("read count bound", 32'(reads), 32'(6 * cnt));
            else chk("mem_addr", o_addr, exp_addrs.pop_front());
            pending = 1'b1; pend_addr = o_addr; lat = int'($urandom_range(3));
         end
         if (genuine) pending = 1'b0;
         if (o_avail && i_rd) begin
            words++;
            if (exp_words.size() == 0) chk("word count bound", 32'(words), 32'(8 * cnt));
            else begin
               e = exp_words.pop_front();
               chk("ahb_buffer", o_buf, e);
               if (e == 32'h1 && tex_mode == 2) hold = 10;
            end
         end
         if (o_avail && !i_rd) begin
            chk("held ahb_data_available", 32'(ahb_data_available), 32'd1);
            chk("held ahb_buffer", ahb_buffer, o_buf);
         end
         if (!o_avail && ahb_data_available && exp_words.size() > 0 && exp_words[0] == 32'h0)
            chk("FRAME_START only after drain", 32'(i_tex), 32'd0);
         chk("no mem_req while presenting", 32'(mem_req & ahb_data_available), 32'd0);
         chk("busy during frame", 32'(busy), 32'd1);
         if (done) begin
            dones++;
            sent = int'(tri_sent);
            chk("words left at done", 32'(exp_words.size()), 32'd0);
            fin = 1'b1;
         end
      end
      if (!fin) chk("frame done within budget", 32'(fin), 32'd1);
      idle_inputs();
      @(posedge clk); #1;
      if (done) dones++;
      chk("idle after done", 32'(busy), 32'd0);
   endtask

   initial begin
      vec_t vt[5];
      int   reads, words, sent, dones, cnt, n;
      bit   got;

      vt[0] = '{32'h0000_0100, 1, 100, 0, 1'b0,  6,  8, 1};  // reference triangle
      vt[1] = '{32'h0000_0100, 1, 100, 0, 1'b1,  6,  8, 1};  // back-pressure
      vt[2] = '{32'h0000_4000, 2, 100, 2, 1'b0, 12, 16, 2};  // drain gating
      vt[3] = '{32'hFFFF_FFF0, 2,  70, 1, 1'b0, 12, 16, 2};  // address wrap
      vt[4] = '{32'h8000_0000, 3,  50, 1, 1'b1, 18, 24, 3};

      idle_inputs();
      base_addr = '0; tri_count = '0;
      #1 rst = 1'b1;
      #1;
      chk("reset mem_req",   32'(mem_req), 32'd0);
      chk("reset mem_addr",  mem_addr, 32'd0);
      chk("reset ahb_buffer", ahb_buffer, 32'd0);
      chk("reset ahb_data_available", 32'(ahb_data_available), 32'd0);
      chk("reset busy",      32'(busy), 32'd0);
      chk("reset done",      32'(done), 32'd0);
      chk("reset tri_sent",  32'(tri_sent), 32'd0);
`ifdef TRI_FETCH_TIMEOUT_EN
      chk("reset timeout_err", 32'(timeout_err), 32'd0);
`endif
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;

      // Scenario table
      for (int i = 0; i < 5; i++) begin
         run_frame(vt[i].base, vt[i].cnt, vt[i].rd_pct, vt[i].tex_mode, vt[i].bp,
                   reads, words, sent, dones);
         chk("vec reads",    32'(reads), 32'(vt[i].exp_reads));
         chk("vec words",    32'(words), 32'(vt[i].exp_words));
         chk("vec tri_sent", 32'(sent),  32'(vt[i].exp_sent));
         chk("vec done once", 32'(dones), 32'd1);
      end

      // Zero count: one busy cycle with done, no read
      start = 1'b1; base_addr = 32'h0000_0700; tri_count = 16'd0;
      @(posedge clk); #1;
      start = 1'b0;
      chk("zero busy",    32'(busy), 32'd1);
      chk("zero done",    32'(done), 32'd1);
      chk("zero mem_req", 32'(mem_req), 32'd0);
      @(posedge clk); #1;
      chk("zero busy end", 32'(busy), 32'd0);
      chk("zero done end", 32'(done), 32'd0);
      chk("zero mem_req end", 32'(mem_req), 32'd0);
      chk("zero tri_sent", 32'(tri_sent), 32'd0);

      // Reset while a read is outstanding
      start = 1'b1; base_addr = 32'h0000_2000; tri_count = 16'd2;
      ahb_user_read_buffer = 1'b1; texel_ready = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
         mem_grant = mem_req;
         got = mem_req;
         @(posedge clk); #1;
      end
      mem_grant = 1'b0;
      chk("reached read wait", 32'(got), 32'd1);
      chk("wait mem_req low", 32'(mem_req), 32'd0);
      chk("wait mem_addr", mem_addr, 32'h0000_2000);
      #2 rst = 1'b1;
      #1;
      chk("async rst mem_req",  32'(mem_req), 32'd0);
      chk("async rst mem_addr", mem_addr, 32'd0);
      chk("async rst ahb_buffer", ahb_buffer, 32'd0);
      chk("async rst ahb_data_available", 32'(ahb_data_available), 32'd0);
      chk("async rst busy",     32'(busy), 32'd0);
      chk("async rst done",     32'(done), 32'd0);
      chk("async rst tri_sent", 32'(tri_sent), 32'd0);
      idle_inputs();
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      run_frame(32'h0000_3000, 1, 100, 0, 1'b0, reads, words, sent, dones);
      chk("post-reset reads", 32'(reads), 32'd6);
      chk("post-reset tri_sent", 32'(sent), 32'd1);

      // Randomized frames
      for (int i = 0; i < 6; i++) begin
         cnt = int'($urandom_range(1, 3));
         run_frame($urandom & 32'hFFFF_FFFC, cnt, int'($urandom_range(30, 100)),
                   int'($urandom_range(0, 2)), 1'($urandom_range(1)),
                   reads, words, sent, dones);
         chk("rand reads",     32'(reads), 32'(6 * cnt));
         chk("rand words",     32'(words), 32'(8 * cnt));
         chk("rand tri_sent",  32'(sent),  32'(cnt));
         chk("rand done once", 32'(dones), 32'd1);
      end

`ifdef TRI_FETCH_TIMEOUT_EN
      // Read data withheld: abort after 256 cycles in the wait
      start = 1'b1; base_addr = 32'h0000_0500; tri_count = 16'd1;
      ahb_user_read_buffer = 1'b1; texel_ready = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
         mem_grant = mem_req;
         got = mem_req;
         @(posedge clk); #1;
      end
      mem_grant = 1'b0;
      chk("timeout reached read wait", 32'(got), 32'd1);
      n = 0;
      while (!done && n < 400) begin
         @(posedge clk); #1;
         n++;
      end
      chk("timeout cycles", 32'(n), 32'd256);
      chk("timeout_err set", 32'(timeout_err), 32'd1);
      chk("timeout tri_sent", 32'(tri_sent), 32'd0);
      idle_inputs();
      @(posedge clk); #1;
      chk("timeout idle", 32'(busy), 32'd0);
      chk("timeout_err sticky", 32'(timeout_err), 32'd1);
      start = 1'b1; tri_count = 16'd0;
      @(posedge clk); #1;
      start = 1'b0;
      chk("timeout_err cleared by start", 32'(timeout_err), 32'd0);
      @(posedge clk); #1;
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
